// File: rtl/ram_pipelined_if.sv
// ram_pipelined_if: fetch and data port bundle for ram_pipelined
interface ram_pipelined_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int FETCH_W = 32
);
  logic [2:0] state;
  logic f_req, f_ready, f_valid, f_error;
  logic [ADDR_W-1:0] f_addr;
  logic [FETCH_W-1:0] f_data;
  logic d_req, d_we, d_ready, d_valid, d_error;
  logic [1:0] d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic init_busy;
  modport master (
    output state, f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata,
    input f_ready, f_valid, f_data, f_error, d_ready, d_valid, d_rdata, d_error, init_busy
  );
  modport slave (
    input state, f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata,
    output f_ready, f_valid, f_data, f_error, d_ready, d_valid, d_rdata, d_error, init_busy
  );
endinterface

// File: rtl/ram_pipelined.sv
// ram_pipelined: byte RAM with fetch and sized data ports, RD_LATENCY read pipe, sequenced clear.
// Define RAM_ALIGN_CHECK_EN to report misaligned accesses as errors.
module ram_pipelined #(
  parameter int MEM_SIZE = 524288,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int FETCH_W = 32,
  parameter int RD_LATENCY = 1,
  parameter logic [2:0] MEM_STATE = 3'b100
) (
  input logic clk,
  input logic reset,
  ram_pipelined_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int FB = FETCH_W / 8;
  localparam int WORDS = MEM_SIZE / NB;
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int MW = $clog2(MEM_SIZE);
  typedef enum logic {CLEAR, RUN} st_t;
  st_t st;
  logic [CW-1:0] cnt;
  logic [7:0] mem [MEM_SIZE];
  logic f_acc, d_acc, f_err, d_err, d_wr;
  logic [7:0] d_be;
  logic [3:0] d_n;
  logic [FETCH_W-1:0] f_rd;
  logic [DATA_W-1:0] d_rd;
  logic [RD_LATENCY-1:0] fv, dv, fe, de;
  logic [FETCH_W-1:0] fd [RD_LATENCY];
  logic [DATA_W-1:0] dd [RD_LATENCY];
  assign d_n = 4'd1 << bus.d_size;
  assign d_be = bus.d_size == 2'd3 ? 8'hFF : bus.d_size == 2'd2 ? 8'h0F : bus.d_size == 2'd1 ? 8'h03 : 8'h01;
  assign f_acc = bus.f_req && st == RUN;
  assign d_acc = bus.d_req && st == RUN;
`ifdef RAM_ALIGN_CHECK_EN
  assign f_err = bus.f_addr > ADDR_W'(MEM_SIZE - FB) || |(bus.f_addr & ADDR_W'(FB - 1));
  assign d_err = bus.d_addr > ADDR_W'(MEM_SIZE) - ADDR_W'(d_n) || |(bus.d_addr[3:0] & (d_n - 4'd1));
`else
  assign f_err = bus.f_addr > ADDR_W'(MEM_SIZE - FB);
  assign d_err = bus.d_addr > ADDR_W'(MEM_SIZE) - ADDR_W'(d_n);
`endif
  assign d_wr = d_acc && bus.d_we && !d_err && bus.state == MEM_STATE;
  assign bus.f_ready = st == RUN;
  assign bus.d_ready = st == RUN;
  assign bus.init_busy = st == CLEAR;
  assign bus.f_valid = fv[RD_LATENCY-1];
  assign bus.f_error = fe[RD_LATENCY-1];
  assign bus.f_data = fd[RD_LATENCY-1];
  assign bus.d_valid = dv[RD_LATENCY-1];
  assign bus.d_error = de[RD_LATENCY-1];
  assign bus.d_rdata = dd[RD_LATENCY-1];
  // Reads sample the array before this edge's write lands, so a same-edge fetch sees old data
  always_comb begin
    f_rd = '0;
    d_rd = '0;
    for (int i = 0; i < FB; i++) f_rd[8*i +: 8] = mem[MW'(bus.f_addr + ADDR_W'(i))];
    for (int i = 0; i < 8; i++) d_rd[8*i +: 8] = d_be[i] ? mem[MW'(bus.d_addr + ADDR_W'(i))] : 8'h0;
  end
  always_ff @(posedge clk)
    if (st == CLEAR)
      for (int i = 0; i < NB; i++) mem[MW'(NB * int'(cnt) + i)] <= 8'h0;
    else if (d_wr)
      for (int i = 0; i < 8; i++) if (d_be[i]) mem[MW'(bus.d_addr + ADDR_W'(i))] <= bus.d_wdata[8*i +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= CLEAR;
      cnt <= '0;
      fv <= '0;
      fe <= '0;
      dv <= '0;
      de <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        fd[i] <= '0;
        dd[i] <= '0;
      end
    end else begin
      if (st == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WORDS - 1)) st <= RUN;
      end
      fv[0] <= f_acc;
      fe[0] <= f_acc && f_err;
      fd[0] <= f_acc && !f_err ? f_rd : '0;
      dv[0] <= d_acc;
      de[0] <= d_acc && d_err;
      dd[0] <= d_acc && !d_err && !bus.d_we ? d_rd : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        fv[i] <= fv[i-1];
        fe[i] <= fe[i-1];
        fd[i] <= fd[i-1];
        dv[i] <= dv[i-1];
        de[i] <= de[i-1];
        dd[i] <= dd[i-1];
      end
    end
endmodule
